// File: rtl/ysyx_icache.sv
// Direct-mapped read-only instruction cache between the IFU fetch port and the arbiter.
// Hits answer in one cycle; misses refill the whole line in word order 0..N-1.
module ysyx_icache #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SET_BITS  = 4,
  parameter int WORD_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  input  logic              fence_i,
  output logic [ADDR_W-1:0] mem_araddr_o,
  output logic              mem_arvalid_o,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int TAG_W = ADDR_W - SET_BITS - WORD_BITS - 2;
  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << WORD_BITS;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESP
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [SETS-1:0]      r_valid;
  logic [TAG_W-1:0]     r_tag  [SETS];
  logic [DATA_W-1:0]    r_data [SETS][WORDS];

  logic [TAG_W-1:0]     r_reqTag;
  logic [SET_BITS-1:0]  r_reqSet;
  logic [WORD_BITS-1:0] r_reqWord;
  logic [WORD_BITS-1:0] r_cnt;
  logic                 r_fencePend;
  logic                 r_refillKill;
  logic [DATA_W-1:0]    r_rdata;
  logic [31:0]          r_hitCnt;
  logic [31:0]          r_missCnt;

  logic [TAG_W-1:0]     w_tag;
  logic [SET_BITS-1:0]  w_set;
  logic [WORD_BITS-1:0] w_word;
  logic                 w_fence;
  logic                 w_hit;
  logic                 w_lastBeat;
  logic                 w_beatDone;
  logic [1:0]           w_unused;

  assign w_tag      = ifu_araddr[ADDR_W-1 -: TAG_W];
  assign w_set      = ifu_araddr[SET_BITS+WORD_BITS+1 : WORD_BITS+2];
  assign w_word     = ifu_araddr[WORD_BITS+1 : 2];
  assign w_unused   = ifu_araddr[1:0];
  assign w_fence    = fence_i | r_fencePend;
  assign w_hit      = ifu_arvalid & r_valid[w_set] & (r_tag[w_set] == w_tag);
  assign w_lastBeat = &r_cnt;
  assign w_beatDone = (r_state == REFILL) & mem_rvalid;

  assign ifu_rdata_o = r_rdata;
  assign hit_cnt_o   = r_hitCnt;
  assign miss_cnt_o  = r_missCnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // A pending or incoming fence takes the IDLE cycle, so the lookup waits one cycle.
  always_comb begin
    w_nextState   = r_state;
    ifu_rvalid_o  = 1'b0;
    mem_arvalid_o = 1'b0;
    mem_araddr_o  = '0;
    unique case (r_state)
      IDLE: begin
        if (!w_fence && ifu_arvalid) w_nextState = w_hit ? RESP : REFILL;
      end
      REFILL: begin
        mem_arvalid_o = 1'b1;
        mem_araddr_o  = {r_reqTag, r_reqSet, r_cnt, 2'b00};
        if (mem_rvalid && w_lastBeat) w_nextState = RESP;
      end
      RESP: begin
        ifu_rvalid_o = 1'b1;
        w_nextState  = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_beatDone) begin
      r_data[r_reqSet][r_cnt] <= mem_rdata;
      if (w_lastBeat) r_tag[r_reqSet] <= r_reqTag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      r_reqTag     <= '0;
      r_reqSet     <= '0;
      r_reqWord    <= '0;
      r_cnt        <= '0;
      r_fencePend  <= 1'b0;
      r_refillKill <= 1'b0;
      r_rdata      <= '0;
      r_hitCnt     <= '0;
      r_missCnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_fence) begin
            r_valid     <= '0;
            r_fencePend <= 1'b0;
          end else if (ifu_arvalid) begin
            if (w_hit) begin
              r_rdata  <= r_data[w_set][w_word];
              r_hitCnt <= r_hitCnt + 32'd1;
            end else begin
              r_reqTag     <= w_tag;
              r_reqSet     <= w_set;
              r_reqWord    <= w_word;
              r_cnt        <= '0;
              r_missCnt    <= r_missCnt + 32'd1;
              r_refillKill <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (fence_i) begin
            r_fencePend  <= 1'b1;
            r_refillKill <= 1'b1;
          end
          // A fence arriving on the final beat still leaves the line invalid.
          if (mem_rvalid) begin
            if (r_cnt == r_reqWord) r_rdata <= mem_rdata;
            if (w_lastBeat) r_valid[r_reqSet] <= ~(r_refillKill | fence_i);
            else            r_cnt <= r_cnt + WORD_BITS'(1);
          end
        end
        RESP: begin
          if (fence_i) r_fencePend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_icache.sv
// Self-checking bench for ysyx_icache: table vectors, directed corner sequences and
// randomized fetches against a line-residency reference model; memory returns word = address.
module tb_ysyx_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ifu_araddr = '0;
  logic        ifu_arvalid = 1'b0;
  logic [31:0] ifu_rdata_o;
  logic        ifu_rvalid_o;
  logic        fence_i = 1'b0;
  logic [31:0] mem_araddr_o;
  logic        mem_arvalid_o;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  int          numChecks = 0;
  int          numFails = 0;
  int          memWait = 1;
  logic [31:0] beatQ[$];

  // Reference model: which 16-byte line each set holds, plus hit/miss tallies.
  bit          mdlValid[16];
  logic [31:0] mdlLine[16];
  int          mdlHits;
  int          mdlMisses;
  bit          mdlPend;

  typedef struct {
    bit          doReset;
    logic [31:0] addr;
    bit          expHit;
    logic [31:0] expHits;
    logic [31:0] expMisses;
  } vec_t;

  vec_t vecs[7];

  ysyx_icache dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_araddr   (ifu_araddr),
    .ifu_arvalid  (ifu_arvalid),
    .ifu_rdata_o  (ifu_rdata_o),
    .ifu_rvalid_o (ifu_rvalid_o),
    .fence_i      (fence_i),
    .mem_araddr_o (mem_araddr_o),
    .mem_arvalid_o(mem_arvalid_o),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Arbiter model: each beat is answered in the memWait-th cycle of its request.
  int          waitCnt = 0;
  bit          beatOpen = 0;
  logic [31:0] holdAddr = '0;
  always @(negedge clk) begin
    if (rst || !mem_arvalid_o) begin
      waitCnt    = 0;
      beatOpen   = 0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end else begin
      if (beatOpen) checkOutput("araddrStable", mem_araddr_o, holdAddr);
      holdAddr = mem_araddr_o;
      waitCnt++;
      if (waitCnt >= memWait) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_araddr_o;
        waitCnt    = 0;
        beatOpen   = 0;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        beatOpen   = 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && mem_arvalid_o && mem_rvalid) beatQ.push_back(mem_araddr_o);
  end

  task automatic modelReset();
    for (int s = 0; s < 16; s++) begin
      mdlValid[s] = 0;
      mdlLine[s]  = '0;
    end
    mdlHits   = 0;
    mdlMisses = 0;
    mdlPend   = 0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst         = 1'b1;
    ifu_arvalid = 1'b0;
    fence_i     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstRvalid", ifu_rvalid_o, 0);
    checkOutput("rstRdata", ifu_rdata_o, 0);
    checkOutput("rstMemArvalid", mem_arvalid_o, 0);
    checkOutput("rstMemAraddr", mem_araddr_o, 0);
    checkOutput("rstHitCnt", hit_cnt_o, 0);
    checkOutput("rstMissCnt", miss_cnt_o, 0);
    rst = 1'b0;
    modelReset();
    beatQ.delete();
  endtask

  // One fetch: optional fence together with the request, or a fence pulse once
  // fenceAtBeat refill beats have completed. Called at a negedge.
  task automatic applyStimulus(input logic [31:0] addr, input int fenceAtBeat, input bit fenceWithReq,
                               output int beats, output int lat);
    logic [31:0] line;
    int          set;
    int          extra;
    bit          hit;
    int          expLat;
    bit          got;
    bit          fenced;
    logic [31:0] held;
    line  = addr & 32'hFFFF_FFF0;
    set   = int'(addr[7:4]);
    extra = 0;
    if (fenceWithReq || mdlPend) begin
      for (int s = 0; s < 16; s++) mdlValid[s] = 0;
      mdlPend = 0;
      extra   = 1;
    end
    hit    = mdlValid[set] && (mdlLine[set] == line);
    expLat = extra + (hit ? 1 : 4 * memWait + 1);
    if (hit) mdlHits++;
    else begin
      mdlMisses++;
      mdlLine[set]  = line;
      mdlValid[set] = (fenceAtBeat < 0);
      if (fenceAtBeat >= 0) mdlPend = 1;
    end

    beatQ.delete();
    ifu_araddr  = addr;
    ifu_arvalid = 1'b1;
    fence_i     = fenceWithReq;
    lat    = 0;
    got    = 0;
    fenced = 0;
    while (lat < 1000 && !got) begin
      @(negedge clk);
      lat++;
      fence_i = 1'b0;
      if (ifu_rvalid_o) got = 1;
      else if (fenceAtBeat >= 0 && !fenced && beatQ.size() == fenceAtBeat) begin
        fence_i = 1'b1;
        fenced  = 1;
      end
    end
    beats = beatQ.size();
    checkOutput("rvalidSeen", got, 1);
    ifu_arvalid = 1'b0;
    fence_i     = 1'b0;
    if (!got) return;
    checkOutput("rdata", ifu_rdata_o, addr & 32'hFFFF_FFFC);
    checkOutput("latency", lat, expLat);
    checkOutput("beatCount", beats, hit ? 0 : 4);
    if (!hit && beats == 4)
      for (int k = 0; k < 4; k++) checkOutput("beatAddr", beatQ[k], line + 32'(4 * k));
    held = ifu_rdata_o;
    @(negedge clk);
    checkOutput("rvalidPulse", ifu_rvalid_o, 0);
    checkOutput("rdataHold", ifu_rdata_o, held);
    checkOutput("hitCnt", hit_cnt_o, mdlHits);
    checkOutput("missCnt", miss_cnt_o, mdlMisses);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats;
    int lat;
    int guard;

    vecs[0] = '{1'b1, 32'h3000_0008, 1'b0, 32'd0, 32'd1};
    vecs[1] = '{1'b0, 32'h3000_0000, 1'b1, 32'd1, 32'd1};
    vecs[2] = '{1'b0, 32'h3000_000C, 1'b1, 32'd2, 32'd1};
    vecs[3] = '{1'b1, 32'h3000_0000, 1'b0, 32'd0, 32'd1};
    vecs[4] = '{1'b0, 32'h3000_0100, 1'b0, 32'd0, 32'd2};
    vecs[5] = '{1'b0, 32'h3000_0000, 1'b0, 32'd0, 32'd3};
    vecs[6] = '{1'b0, 32'h3000_0004, 1'b1, 32'd1, 32'd3};

    memWait = 1;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].doReset) resetDut();
      applyStimulus(vecs[i].addr, -1, 1'b0, beats, lat);
      checkOutput("vecHit", (beats == 0), vecs[i].expHit);
      checkOutput("vecHitCnt", hit_cnt_o, vecs[i].expHits);
      checkOutput("vecMissCnt", miss_cnt_o, vecs[i].expMisses);
    end

    // Stalled arbiter: every beat takes 10 cycles.
    resetDut();
    memWait = 10;
    applyStimulus(32'h3000_0004, -1, 1'b0, beats, lat);
    checkOutput("stallLatency", lat, 41);
    memWait = 1;

    // Fence during a refill: word returned, line and older lines dropped.
    resetDut();
    applyStimulus(32'h3000_0000, -1, 1'b0, beats, lat);
    applyStimulus(32'h3000_0020, 2, 1'b0, beats, lat);
    applyStimulus(32'h3000_0020, -1, 1'b0, beats, lat);
    checkOutput("fenceRefetchMiss", beats, 4);
    applyStimulus(32'h3000_0000, -1, 1'b0, beats, lat);
    checkOutput("fenceOldLineMiss", beats, 4);
    checkOutput("fenceMissCnt", miss_cnt_o, 4);

    // Reset after the first refill beat.
    resetDut();
    applyStimulus(32'h3000_0000, -1, 1'b0, beats, lat);
    beatQ.delete();
    ifu_araddr  = 32'h3000_0040;
    ifu_arvalid = 1'b1;
    guard = 0;
    while (beatQ.size() < 1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rstMidBeatSeen", (beatQ.size() >= 1), 1);
    rst         = 1'b1;
    ifu_arvalid = 1'b0;
    @(negedge clk);
    checkOutput("rstMidArvalid", mem_arvalid_o, 0);
    checkOutput("rstMidRvalid", ifu_rvalid_o, 0);
    checkOutput("rstMidHitCnt", hit_cnt_o, 0);
    checkOutput("rstMidMissCnt", miss_cnt_o, 0);
    rst = 1'b0;
    modelReset();
    applyStimulus(32'h3000_0000, -1, 1'b0, beats, lat);
    checkOutput("rstMidRefetchMiss", beats, 4);

    // Randomized fetches over 64 lines sharing 16 sets.
    resetDut();
    for (int n = 0; n < 80; n++) begin
      memWait = $urandom_range(1, 3);
      applyStimulus(32'h3000_0000 + ($urandom_range(0, 255) << 2), -1,
                    ($urandom_range(0, 9) == 0), beats, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/ysyx_icache.md
Name: ysyx_icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU fetch port and the bus arbiter's IFU read port (ifu_araddr/ifu_arvalid/ifu_rdata_o/ifu_rvalid_o).
- Hits return in one cycle.
- Misses refill a whole line as sequential single-beat word reads through the arbiter.
- fence_i invalidates the whole cache.
- Hit and miss performance counters are exported.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width; the bus word is 4 bytes.
- SET_BITS, 4, log2 number of lines (16).
- WORD_BITS, 2, log2 words per line (4 words, 16 B).
- Derived: TAG_W = ADDR_W - SET_BITS - WORD_BITS - 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ifu_araddr  in  ADDR_W  fetch address; bits [1:0] are ignored.
- ifu_arvalid  in  1  fetch request; held with a stable address until ifu_rvalid_o.
- ifu_rdata_o  out  DATA_W  fetched instruction word.
- ifu_rvalid_o  out  1  one-cycle pulse; ifu_rdata_o is valid in that cycle.
- fence_i  in  1  invalidate-all request (pulse).
- mem_araddr_o  out  ADDR_W  refill word address to the arbiter (ifu_araddr side).
- mem_arvalid_o  out  1  refill request to the arbiter.
- mem_rdata  in  DATA_W  word from the arbiter (ifu_rdata_o side).
- mem_rvalid  in  1  word valid from the arbiter; may be withheld for any number of cycles (LSU priority).
- hit_cnt_o  out  32  hit counter.
- miss_cnt_o  out  32  miss counter.

Behaviour:
- Address split: tag = araddr[ADDR_W-1 : SET_BITS+WORD_BITS+2], set = araddr[SET_BITS+WORD_BITS+1 : WORD_BITS+2], word = araddr[WORD_BITS+1 : 2].
- Storage: valid[2^SET_BITS], tag[2^SET_BITS][TAG_W], data[2^SET_BITS][2^WORD_BITS][DATA_W], all flops.
- Reset:
  - State IDLE, every valid bit 0, counters 0, fence_pend 0.
  - ifu_rvalid_o, ifu_rdata_o, mem_arvalid_o and mem_araddr_o are all 0.
- State machine:
  - IDLE:
    - If fence_i or fence_pend: clear all valid bits and fence_pend this cycle. No lookup is performed, even if ifu_arvalid is high; the request is served on a later cycle as a miss.
    - Else if ifu_arvalid and (valid[set] and tag[set]==tag): hit.
      - Register data[set][word] into ifu_rdata_o.
      - hit_cnt += 1.
      - Go to RESP.
    - Else if ifu_arvalid: miss.
      - Latch req_addr.
      - cnt = 0.
      - miss_cnt += 1.
      - refill_kill = 0.
      - Go to REFILL.
  - REFILL:
    - mem_arvalid_o = 1 and mem_araddr_o = {req_tag, req_set, cnt, 2'b00}, held stable until mem_rvalid.
    - On mem_rvalid: data[req_set][cnt] <= mem_rdata.
      - If cnt == req_word, also capture mem_rdata into ifu_rdata_o.
      - If cnt == 2^WORD_BITS-1: valid[req_set] <= !refill_kill, tag[req_set] <= req_tag, go to RESP.
      - Else cnt += 1.
    - The counter wraps only at the end of the line; words are fetched in order 0..N-1, with no critical-word-first.
    - fence_i during REFILL: set fence_pend and refill_kill. The line completes and the requested word is still returned, but the line is left invalid.
  - RESP:
    - ifu_rvalid_o = 1 for exactly this cycle.
    - mem_arvalid_o = 0.
    - Next state is IDLE.
    - fence_i here sets fence_pend.
- Latency from ifu_arvalid being sampled high in IDLE:
  - Hit: 1 cycle to RESP.
  - Miss: (sum of the per-word mem_rvalid waits) + 1.
- Between requests, ifu_rvalid_o is low and ifu_rdata_o holds its last value.
- Every IDLE cycle with ifu_arvalid high and no fence is a new request. The IFU must change or drop arvalid after ifu_rvalid_o.
- ifu_araddr is not sampled outside IDLE, so address changes during REFILL are ignored.
- Counters are 32-bit and wrap modulo 2^32.
- rst asserted mid-REFILL:
  - Return to IDLE next edge with all lines invalid.
  - mem_arvalid_o drops immediately after that edge.
  - The arbiter is reset by the same rst.
- mem_rvalid is ignored outside REFILL.

Test Plan:
- Cold miss: rst, then fetch 0x30000008, with the memory model returning word = address. The bench must see:
  - Exactly 4 arvalid beats at 0x30000000, 0x30000004, 0x30000008, 0x3000000C.
  - ifu_rdata_o = 0x30000008 with a single-cycle ifu_rvalid_o.
  - miss_cnt_o = 1.
- Hit after refill: fetch 0x30000000, then 0x3000000C. The bench must see:
  - Each answered 1 cycle after request, with no mem_arvalid_o.
  - Data 0x30000000 and 0x3000000C.
  - hit_cnt_o = 2.
- Conflict eviction: fetch 0x30000000, then 0x30000100 (same set, new tag), then 0x30000000. The bench must see three misses (miss_cnt_o = 3), each with a 4-beat refill.
- Stalled bus: hold mem_rvalid low for 10 cycles per beat during a miss on 0x30000004. The bench must see:
  - mem_araddr_o stable during each wait.
  - The response arriving 41 cycles after the request.
  - Data correct.
- fence_i mid-refill: pulse fence_i during beat 2 of a miss on 0x30000020. The bench must see:
  - The word is still returned.
  - The next fetch of 0x30000020 misses again.
  - A prior-cached line 0x30000000 also misses afterwards.
- Reset mid-refill: assert rst after beat 1. The bench must see:
  - mem_arvalid_o = 0 and ifu_rvalid_o = 0 next cycle.
  - Counters 0.
  - A fetch of 0x30000000 misses.
